psum_requant: RTL and testbench

Output stage that sits directly below the bottom row of the systolic MAC array and consumes one column's `p_o` stream. It accumulates partial sums across several input-channel passes in a local buffer and applies the final requantization. Requantization converts from the P format to the A format with rounding, optional ReLU and saturation. Results leave through a valid/ready handshake toward activation memory. One instance serves one array column.

---
 rtl/psum_requant.sv | 180 ++++++++++++++++++
 tb/tb_psum_requant.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/psum_requant.sv
// psum_requant: output stage below one column of the systolic MAC array.
// It accumulates a column's partial sums over several input-channel passes
// in a local buffer. On the last pass it requantizes each sum from the P
// format to the A format (round-half-up, optional ReLU, saturation) and
// presents it through a valid/ready handshake.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start with a valid config
//   RUN   | accepting psums; accumulates in non-last passes, emits in the last
//   DRAIN | last psum accepted; waiting for the final result to be taken
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle pulse; latches cfg_* (honoured in IDLE only)
//   cfg_len         psums per pass, 1..DEPTH
//   cfg_passes      number of passes, >= 1
//   cfg_relu        clamp negative results to 0 before saturation
//   in_valid/in_psum/in_ready     psum stream from the array column
//   out_valid/out_data/out_ready  requantized activations to memory
//   busy            high whenever state != IDLE
//   done            one-cycle pulse on return to IDLE
module psum_requant #(
  parameter int A_BITWIDTH = 16,
  parameter int A_FRAC_BIT = 8,
  parameter int P_BITWIDTH = 40,
  parameter int P_FRAC_BIT = 14,
  parameter int DEPTH      = 16,
  parameter int PASS_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(DEPTH+1)-1:0]   cfg_len,
  input  logic [PASS_W-1:0]            cfg_passes,
  input  logic                         cfg_relu,
  input  logic                         in_valid,
  input  logic [P_BITWIDTH-1:0]        in_psum,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [A_BITWIDTH-1:0]        out_data,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done
);

  localparam int LEN_W = $clog2(DEPTH+1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int P     = P_BITWIDTH;
  localparam int A     = A_BITWIDTH;
  localparam int SH    = P_FRAC_BIT - A_FRAC_BIT;
  localparam int SHM1  = (SH > 0) ? SH - 1 : 0;

  // Rounding constant is zero when no shift is needed, so one datapath covers SH==0.
  localparam logic signed [P:0] RND = (SH > 0) ? ((P+1)'(1) << SHM1) : '0;

  localparam logic [P-1:0] P_MAX = {1'b0, {(P-1){1'b1}}};
  localparam logic [P-1:0] P_MIN = {1'b1, {(P-1){1'b0}}};
  localparam logic signed [P:0] A_MAX_X = {{(P+2-A){1'b0}}, {(A-1){1'b1}}};
  localparam logic signed [P:0] A_MIN_X = {{(P+2-A){1'b1}}, {(A-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t            state, state_nx;
  logic [LEN_W-1:0]  len_q;
  logic [PASS_W-1:0] passes_q;
  logic [PASS_W-1:0] pass;
  logic              relu_q;
  logic [IDX_W-1:0]  idx;
  logic [P-1:0]      acc_buf [DEPTH];

  logic              cfg_ok;
  logic              accept;
  logic              last_pass;
  logic              idx_last;
  logic [P-1:0]      rd;
  logic [P:0]        addend;
  logic [P:0]        sum_x;
  logic [P-1:0]      sum_sat;
  logic signed [P:0] rq_x;
  logic [A-1:0]      rq_a;

  assign cfg_ok    = start && (cfg_len != '0) && (cfg_len <= LEN_W'(DEPTH)) &&
                     (cfg_passes != '0);
  assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign last_pass = (pass == passes_q - PASS_W'(1));
  assign idx_last  = (LEN_W'(idx) == len_q - LEN_W'(1));
  assign busy      = (state != S_IDLE);
  assign rd        = acc_buf[idx];

  // Accumulate at P+1 bits, then clamp back to the P range.
  always_comb begin
    addend  = (pass == '0) ? '0 : {rd[P-1], rd};
    sum_x   = {in_psum[P-1], in_psum} + addend;
    sum_sat = sum_x[P-1:0];
    if (sum_x[P] != sum_x[P-1]) begin
      sum_sat = sum_x[P] ? P_MIN : P_MAX;
    end
  end

  // Requantize: round-half-up arithmetic shift, optional ReLU, saturate to A.
  always_comb begin
    rq_x = ($signed({sum_sat[P-1], sum_sat}) + RND) >>> SH;
    if (relu_q && rq_x[P]) begin
      rq_x = '0;
    end
    if (rq_x > A_MAX_X) begin
      rq_a = {1'b0, {(A-1){1'b1}}};
    end else if (rq_x < A_MIN_X) begin
      rq_a = {1'b1, {(A-1){1'b0}}};
    end else begin
      rq_a = rq_x[A-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (cfg_ok) state_nx = S_RUN;
      S_RUN:   if (accept && last_pass && idx_last) state_nx = S_DRAIN;
      S_DRAIN: if (!out_valid || out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      passes_q  <= '0;
      relu_q    <= 1'b0;
      idx       <= '0;
      pass      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      done <= (state == S_DRAIN) && (state_nx == S_IDLE);

      if (state == S_IDLE && cfg_ok) begin
        len_q    <= cfg_len;
        passes_q <= cfg_passes;
        relu_q   <= cfg_relu;
        idx      <= '0;
        pass     <= '0;
      end else if (accept) begin
        if (idx_last) begin
          idx  <= '0;
          pass <= pass + PASS_W'(1);
        end else begin
          idx  <= idx + IDX_W'(1);
        end
      end

      // A reload in the same cycle as a handshake keeps out_valid high.
      if (accept && last_pass) begin
        out_valid <= 1'b1;
        out_data  <= rq_a;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Buffer is not reset: pass 0 overwrites every entry before it is read.
  always_ff @(posedge clk) begin
    if (accept && !last_pass) begin
      acc_buf[idx] <= sum_sat;
    end
  end

endmodule

// File: tb/tb_psum_requant.sv
module tb_psum_requant;

  logic              clk;
  logic              rst;
  logic              start;
  logic [4:0]        cfg_len;
  logic [7:0]        cfg_passes;
  logic              cfg_relu;
  logic              in_valid;
  logic [39:0]       in_psum;
  logic              in_ready;
  logic              out_valid;
  logic [15:0]       out_data;
  logic              out_ready;
  logic              busy;
  logic              done;

  psum_requant dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_passes(cfg_passes),
    .cfg_relu  (cfg_relu),
    .in_valid  (in_valid),
    .in_psum   (in_psum),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [15:0] exp_q [$];
  int n_total = 0;
  int n_pass  = 0;
  int done_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every completed output handshake.
  always @(negedge clk) begin
    logic signed [15:0] e;
    if (!rst) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: got %0d expected none", $signed(out_data));
        end else begin
          e = exp_q.pop_front();
          check("out_data", $signed(out_data), e);
        end
      end
    end
  end

  task automatic do_start(input logic [4:0] len, input logic [7:0] passes, input logic relu);
    @(posedge clk); #1;
    start = 1'b1; cfg_len = len; cfg_passes = passes; cfg_relu = relu;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic signed [39:0] p, input bit last, input logic signed [15:0] e);
    int n;
    if (last) exp_q.push_back(e);
    in_valid = 1'b1;
    in_psum  = p;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 for psum %0d", p);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      check(last ? "latency_out_valid" : "nonlast_out_valid", out_valid, last);
    end
  endtask

  task automatic finish_run(input string name);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, busy, 0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    check({name, "_done_count"}, done_cnt, 1);
    done_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cfg_len = '0; cfg_passes = '0; cfg_relu = 1'b0;
    in_valid = 1'b0; in_psum = '0; out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // Single pass, SH=6.
    do_start(5'd4, 8'd1, 1'b0);
    send(40'sd320, 1, 16'sd5);
    send(40'sd96,  1, 16'sd2);
    send(-40'sd96, 1, -16'sd1);
    send(40'sd0,   1, 16'sd0);
    finish_run("single");

    // Three passes accumulated.
    do_start(5'd2, 8'd3, 1'b0);
    send(40'sd64,  0, 0);
    send(40'sd128, 0, 0);
    send(40'sd64,  0, 0);
    send(-40'sd64, 0, 0);
    send(40'sd64,  1, 16'sd3);
    send(40'sd0,   1, 16'sd1);
    finish_run("three_pass");

    // Saturation to A range.
    do_start(5'd2, 8'd1, 1'b0);
    send(40'sd1073741824,  1, 16'sd32767);
    send(-40'sd1073741824, 1, -16'sd32768);
    finish_run("sat");

    // ReLU clamps negatives.
    do_start(5'd2, 8'd1, 1'b1);
    send(-40'sd1073741824, 1, 16'sd0);
    send(40'sd320, 1, 16'sd5);
    finish_run("relu");

    // Accumulation reaching the top of the P range.
    do_start(5'd1, 8'd2, 1'b0);
    send(40'sd274877906943, 0, 0);
    send(40'sd274877906944, 1, 16'sd32767);
    finish_run("psum_sat");

    // Backpressure on the first result.
    do_start(5'd3, 8'd1, 1'b0);
    out_ready = 1'b0;
    send(40'sd320, 1, 16'sd5);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", $signed(out_data), 5);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(40'sd96,  1, 16'sd2);
    send(40'sd192, 1, 16'sd3);
    finish_run("backpressure");

    // Invalid configurations are ignored.
    do_start(5'd0, 8'd1, 1'b0);
    do_start(5'd17, 8'd1, 1'b0);
    do_start(5'd2, 8'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("badcfg_busy", busy, 0);
    check("badcfg_done", done_cnt, 0);

    // Start during RUN is ignored (new config would change the run length).
    do_start(5'd2, 8'd1, 1'b0);
    send(40'sd320, 1, 16'sd5);
    start = 1'b1; cfg_len = 5'd1; cfg_passes = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    check("run_start_busy", busy, 1);
    send(40'sd96, 1, 16'sd2);
    finish_run("start_in_run");

    // Full DEPTH, two passes: outputs 1..16.
    do_start(5'd16, 8'd2, 1'b0);
    for (int i = 0; i < 16; i++) send(40'(i * 64), 0, 0);
    for (int i = 0; i < 16; i++) send(40'sd64, 1, 16'(i + 1));
    finish_run("depth");

    // Reset in the middle of pass 1 with an output pending.
    do_start(5'd2, 8'd2, 1'b0);
    send(40'sd64, 0, 0);
    send(40'sd64, 0, 0);
    out_ready = 1'b0;
    send(40'sd64, 1, 16'sd2);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    done_cnt = 0;

    // Fresh run: pass 0 must overwrite stale buffer contents.
    do_start(5'd2, 8'd2, 1'b0);
    send(40'sd0,   0, 0);
    send(40'sd640, 0, 0);
    send(40'sd64,  1, 16'sd1);
    send(-40'sd64, 1, 16'sd9);
    finish_run("fresh");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
